// File: rtl/alu_nibble_seq.sv
// Sequences a 16-bit operation through an external 4-bit ALU slice, one nibble per cycle,
// chaining the slice carry from nibble 0 up to nibble 3 and assembling the result.
module alu_nibble_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_m1,
    input  logic        op_m0,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    input  logic        op_cin,
    output logic        alu_m1,
    output logic        alu_m0,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_cin,
    input  logic [3:0]  alu_f,
    input  logic        alu_cout,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        carry_q, carry_d;
    logic [15:0] a_lat_q, a_lat_d;
    logic [15:0] b_lat_q, b_lat_d;
    logic        cin_lat_q, cin_lat_d;
    logic        m1_lat_q, m1_lat_d;
    logic        m0_lat_q, m0_lat_d;
    logic [15:0] work_q, work_d;
    logic [15:0] result_q, result_d;
    logic        cout_q, cout_d;

    function automatic logic [3:0] get_nib(input logic [15:0] v, input logic [1:0] idx);
        return v[{idx, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] set_nib(input logic [15:0] v, input logic [1:0] idx,
                                            input logic [3:0] n);
        logic [15:0] r;
        r = v;
        r[{idx, 2'b00} +: 4] = n;
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        cin_lat_d = cin_lat_q;
        m1_lat_d  = m1_lat_q;
        m0_lat_d  = m0_lat_q;
        work_d    = work_q;
        result_d  = result_q;
        cout_d    = cout_q;
        alu_m1    = 1'b0;
        alu_m0    = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_cin   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_lat_d   = op_a;
                    b_lat_d   = op_b;
                    cin_lat_d = op_cin;
                    m1_lat_d  = op_m1;
                    m0_lat_d  = op_m0;
                    cnt_d     = 2'd0;
                    carry_d   = 1'b0;
                    work_d    = 16'h0000;
                    state_d   = RUN;
                end
            end
            RUN: begin
                alu_m1  = m1_lat_q;
                alu_m0  = m0_lat_q;
                alu_a   = get_nib(a_lat_q, cnt_q);
                alu_b   = get_nib(b_lat_q, cnt_q);
                alu_cin = (cnt_q == 2'd0) ? cin_lat_q : carry_q;
                work_d  = set_nib(work_q, cnt_q, alu_f);
                carry_d = alu_cout;
                cnt_d   = cnt_q + 2'd1;
                // Result is published whole on the last nibble so partial sums never leak out.
                if (cnt_q == 2'd3) begin
                    result_d = {alu_f, work_q[11:0]};
                    cout_d   = alu_cout;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            carry_q   <= 1'b0;
            a_lat_q   <= 16'h0000;
            b_lat_q   <= 16'h0000;
            cin_lat_q <= 1'b0;
            m1_lat_q  <= 1'b0;
            m0_lat_q  <= 1'b0;
            work_q    <= 16'h0000;
            result_q  <= 16'h0000;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            a_lat_q   <= a_lat_d;
            b_lat_q   <= b_lat_d;
            cin_lat_q <= cin_lat_d;
            m1_lat_q  <= m1_lat_d;
            m0_lat_q  <= m0_lat_d;
            work_q    <= work_d;
            result_q  <= result_d;
            cout_q    <= cout_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: an add-with-carry slice model on the alu_* ports and a
// scoreboard of whole-word sums popped on every done pulse.
module tb_alu_nibble_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op_m1, op_m0;
    logic [15:0] op_a, op_b;
    logic        op_cin;
    logic        alu_m1, alu_m0;
    logic [3:0]  alu_a, alu_b;
    logic        alu_cin;
    logic [3:0]  alu_f;
    logic        alu_cout;
    logic        busy, done;
    logic [15:0] result;
    logic        cout;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_done  = 0;
    logic [16:0] sb_q[$];
    logic        cin_seen [4];

    always #5 clk = ~clk;

    alu_nibble_seq dut (
        .clk(clk), .rst(rst), .start(start),
        .op_m1(op_m1), .op_m0(op_m0), .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
        .alu_m1(alu_m1), .alu_m0(alu_m0), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout),
        .busy(busy), .done(done), .result(result), .cout(cout)
    );

    // Behavioural slice: plain 4-bit add with carry, mode bits ignored.
    assign {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
        return {1'b0, a} + {1'b0, b} + {16'h0000, cin};
    endfunction

    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [16:0] e;
            n_done++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("result", {16'h0, result}, {16'h0, e[15:0]});
                chk("cout", {31'h0, cout}, {31'h0, e[16]});
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic m1, input logic m0, input bit inj,
                          output int lat, output int busy_n);
        @(negedge clk);
        start  = 1'b1;
        op_a   = a;
        op_b   = b;
        op_cin = cin;
        op_m1  = m1;
        op_m0  = m0;
        sb_q.push_back(ref_sum(a, b, cin));
        lat    = 0;
        busy_n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (i <= 4) cin_seen[i-1] = alu_cin;
            if (i == 1) begin
                chk("alu_m1", {31'h0, alu_m1}, {31'h0, m1});
                chk("alu_m0", {31'h0, alu_m0}, {31'h0, m0});
            end
            if (done && lat == 0) begin
                lat = i;
                chk("done_alu_a", {28'h0, alu_a}, 32'h0);
                chk("done_alu_cin", {31'h0, alu_cin}, 32'h0);
            end
            if (i == 1) begin
                start  = 1'b0;
                op_a   = ~a;
                op_b   = ~b;
                op_cin = ~cin;
                op_m1  = ~m1;
                op_m0  = ~m0;
            end
            if (inj && i == 2) begin
                start = 1'b1;
                op_a  = 16'hAAAA;
                op_b  = 16'h5555;
            end
            if (inj && i == 3) start = 1'b0;
            if (!busy) break;
        end
        if (lat == 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, bsy, d0, first, second;
        rst = 1'b1; start = 1'b1; op_m1 = 1'b1; op_m0 = 1'b1;
        op_a = 16'hBEEF; op_b = 16'hCAFE; op_cin = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_done", {31'h0, done}, 0);
        chk("rst_result", {16'h0, result}, 0);
        chk("rst_cout", {31'h0, cout}, 0);
        chk("rst_alu", {21'h0, alu_m1, alu_m0, alu_a, alu_b, alu_cin}, 0);
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_outs", {8'h0, busy, done, cout, alu_m1, alu_m0, alu_a, alu_b, alu_cin},
                0);
            chk("idle_result", {16'h0, result}, 0);
        end

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, 0, lat, bsy);
        chk("add_latency", lat, 5);
        chk("add_busy_cycles", bsy, 5);
        chk("add_result_5555", {16'h0, result}, 32'h5555);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 0, lat, bsy);
        chk("ripple_cin0", {31'h0, cin_seen[0]}, 0);
        chk("ripple_cin1", {31'h0, cin_seen[1]}, 1);
        chk("ripple_cin2", {31'h0, cin_seen[2]}, 1);
        chk("ripple_cin3", {31'h0, cin_seen[3]}, 1);
        chk("ripple_result", {15'h0, cout, result}, 32'h10000);

        run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 0, lat, bsy);
        chk("cin_only_result", {15'h0, cout, result}, 32'h00001);

        d0 = n_done;
        run_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1, lat, bsy);
        repeat (8) @(negedge clk);
        chk("ignored_start_dones", n_done - d0, 1);
        chk("ignored_start_busy", bsy, 5);
        chk("ignored_start_result", {16'h0, result}, 32'h3333);

        @(negedge clk);
        start = 1'b1; op_a = 16'h1234; op_b = 16'h1111; op_cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_alu_a_nib2", {28'h0, alu_a}, 32'h2);
        rst = 1'b1;
        d0 = n_done;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'h0, busy}, 0);
        chk("abort_done", {31'h0, done}, 0);
        chk("abort_result", {15'h0, cout, result}, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);
        run_op(16'h000A, 16'h0005, 1'b0, 1'b0, 1'b0, 0, lat, bsy);
        chk("after_abort_result", {16'h0, result}, 32'h000F);
        chk("after_abort_latency", lat, 5);

        @(negedge clk);
        start = 1'b1; op_a = 16'h0F0F; op_b = 16'h0101; op_cin = 1'b0;
        sb_q.push_back(ref_sum(16'h0F0F, 16'h0101, 1'b0));
        first = 0; second = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 1) begin
                op_a = 16'h8000; op_b = 16'h8000; op_cin = 1'b1;
                sb_q.push_back(ref_sum(16'h8000, 16'h8000, 1'b1));
            end
            if (i == 7) start = 1'b0;
            if (done) begin
                if (first == 0) first = i;
                else if (second == 0) second = i;
            end
        end
        chk("b2b_second_seen", {31'h0, second != 0}, 1);
        chk("b2b_gap", second - first, 6);

        for (int k = 0; k < 4; k++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0,
                   lat, bsy);
            chk("rand_latency", lat, 5);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
